// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: runs two WIDTH-bit operands LSB-first through a
// 1-bit AND/OR/ADD slice, carrying cin between cycles, with valid/ready on both sides.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);
  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; the source holds its data until then, and out_valid is
  // held high until out_ready is seen.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_result;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cout, r_ovf, r_zero, r_in_ready, r_out_valid;

  logic             w_sub, w_slt, w_arith, w_ai, w_bi, w_sum, w_cnext, w_bit, w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_shift, w_final;

  assign w_slt   = (r_op == 3'b111);
  assign w_sub   = (r_op == 3'b110) || w_slt;
  assign w_arith = (r_op == 3'b010) || w_sub;
  assign w_ai    = r_a[r_cnt];
  assign w_bi    = r_b[r_cnt] ^ w_sub;
  assign w_sum   = w_ai ^ w_bi ^ r_c;
  assign w_cnext = (w_ai & w_bi) | (w_ai & r_c) | (w_bi & r_c);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf   = r_c ^ w_cnext;

  always_comb begin
    w_bit = w_ai & w_bi;
    if (w_arith)           w_bit = w_sum;
    else if (r_op == 3'b001) w_bit = w_ai | w_bi;
  end

  assign w_shift = {w_bit, r_sh[WIDTH-1:1]};
  // SLT reports sign(a-b) corrected for overflow in bit 0 only.
  assign w_final = w_slt ? {{(WIDTH-1){1'b0}}, w_sum ^ w_ovf} : w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_sh        <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_op       <= op;
            r_cnt      <= '0;
            r_c        <= (op == 3'b110) || (op == 3'b111);
            r_sh       <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sh <= w_shift;
          r_c  <= w_cnext;
          if (w_last) begin
            r_result    <= w_final;
            r_zero      <= (w_final == '0);
            r_cout      <= w_arith && !w_slt && w_cnext;
            r_ovf       <= w_arith && !w_slt && w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed self-checking bench for serial_alu_seq (WIDTH=8) with hand-computed results.
module tb_serial_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] er, input logic ec,
                             input logic eo, input logic ez);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, carry_out, ec);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_zero"}, zero, ez);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ack_in_ready", in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic [2:0] top, input logic [W-1:0] er, input logic ec,
                     input logic eo, input logic ez);
    start_op(ta, tb_, top);
    chk({tag, "_busy"}, in_ready, 0);
    wait_result(tag, er, ec, eo, ez);
    ack();
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_ready", in_ready, 1);
    chk("idle_hold_valid", out_valid, 0);

    run("add0f01", 8'h0F, 8'h01, 3'b010, 8'h10, 0, 0, 0);
    run("add7f01", 8'h7F, 8'h01, 3'b010, 8'h80, 0, 1, 0);
    run("addff01", 8'hFF, 8'h01, 3'b010, 8'h00, 1, 0, 1);
    run("sub0001", 8'h00, 8'h01, 3'b110, 8'hFF, 0, 0, 0);
    run("sub0503", 8'h05, 8'h03, 3'b110, 8'h02, 1, 0, 0);
    run("slt8001", 8'h80, 8'h01, 3'b111, 8'h01, 0, 0, 0);
    run("slt0180", 8'h01, 8'h80, 3'b111, 8'h00, 0, 0, 1);
    run("andf03c", 8'hF0, 8'h3C, 3'b000, 8'h30, 0, 0, 0);
    run("orf00f",  8'hF0, 8'h0F, 3'b001, 8'hFF, 0, 0, 0);
    run("op3and",  8'hF0, 8'h3C, 3'b011, 8'h30, 0, 0, 0);

    // Back-pressure: result holds while new requests are offered and ignored.
    start_op(8'h20, 8'h22, 3'b010);
    wait_result("bp", 8'h42, 0, 0, 0);
    a = 8'hAA; b = 8'h55; op = 3'b001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_result", result, 8'h42);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    a = 8'h11; b = 8'h22; op = 3'b010;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_only_ack_state", dbg_state, 0);
    chk("bp_only_ack_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", dbg_state, 1);
    wait_result("bp_next", 8'h33, 0, 0, 0);
    ack();

    // Reset in the middle of a subtraction discards it.
    start_op(8'h09, 8'h04, 3'b110);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_result", result, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run("add0503", 8'h05, 8'h03, 3'b010, 8'h08, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
